alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the original 8 operation encodings, generalised to WIDTH bits. It adds registered results, status flags, and multi-cycle shift/rotate operations executed by an internal FSM. It sits between the register file/decoder and the writeback stage, using valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
SHAMT_W, $clog2(WIDTH), localparam (not overridable); number of B bits used as shift/rotate count.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset
IN_VALID  input  1  request valid
IN_READY  output  1  block can accept a request this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B; B[SHAMT_W-1:0] is the count for shift/rotate ops
S  input  4  opcode
CIN  input  1  carry in (ADD/SUB only)
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
Y  output  WIDTH  result
COUT  output  1  carry / last bit shifted out
Z  output  1  Y == 0
N  output  1  Y[WIDTH-1]
V  output  1  signed overflow (ADD/SUB only, else 0)
ERR  output  1  illegal opcode

Behaviour:
- Reset (RST_N=0 at CLK edge):
  - FSM goes to IDLE; OUT_VALID=0; Y=0; COUT=Z=N=V=ERR=0.
  - Any in-flight op is discarded and produces no output.
  - IN_READY=0 while RST_N=0.
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: multi-cycle shift/multiply in progress.
  - HOLD: OUT_VALID=1, waiting for OUT_READY.
- IN_READY = (state==IDLE) | (state==HOLD & OUT_READY). This is a combinational path from OUT_READY; back-to-back single-cycle ops sustain 1 op/cycle.
- Accept: IN_VALID & IN_READY. A, B, S and CIN are captured at accept; later input changes are ignored.
- Single-cycle ops, latency 1 (OUT_VALID asserted the cycle after accept):
  - 0000 ADD: {COUT,Y} = A+B+CIN, computed at WIDTH+1 bits.
  - 0001 SUB: {COUT,Y} = A+~B+CIN, where COUT=1 means no borrow.
  - 0010 Y=B; 0011 Y=A; 0100 AND; 0101 OR; 0110 Y=~A; 0111 XOR.
- V (ADD/SUB only): operand sign bits equal (using ~B for SUB) and Y sign differs from them.
- Logic/move ops: COUT=0, V=0.
- Shift/rotate ops, one bit per cycle in EXEC:
  - Opcodes: 1000 SHL, 1001 SHR (logical), 1010 ASR, 1011 ROL.
  - cnt = B[SHAMT_W-1:0]. Latency is 1+cnt; cnt=0 gives Y=A, COUT=0, latency 1.
  - COUT = last bit shifted out; for ROL, COUT = final Y[0].
  - V=0.
- Z and N are derived from the final Y for every op.
- Illegal opcodes (1100 without the optional feature, 1101-1111 always): ERR=1, Y=0, all other flags 0, latency 1.
- HOLD: Y and all flags stay stable while OUT_VALID & !OUT_READY.
  - On OUT_VALID & OUT_READY, go to IDLE, or load the next accepted op in the same cycle.
- EXEC: IN_READY=0 and OUT_VALID=0.

Optional Feature:
Macro ALU_SEQ_MUL_EN.
- Defined: opcode 1100 = unsigned multiply, iterative shift-add over WIDTH cycles, latency WIDTH+1.
  - Y = low WIDTH bits of the product.
  - COUT=1 if the high half is nonzero; V=0.
- Undefined: opcode 1100 is illegal (ERR=1). No multiplier datapath or counter bits are synthesised.

Decomposition:
- Package alu_pkg:
  - Opcode localparams (OP_ADD ... OP_MUL).
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_HOLD).
  - Helper function is_multicycle(op).
- Sub-module alu_core: purely combinational WIDTH-parametrised datapath for the 8 single-cycle ops plus COUT/V.
- alu_seq owns the FSM, shift/multiply registers, counter, output registers and Z/N generation.

Test Plan:
- WIDTH=8, ADD A=8'hFF B=8'h01 CIN=0 -> next cycle OUT_VALID=1, Y=8'h00, COUT=1, Z=1, V=0.
- SUB A=8'h80 B=8'h01 CIN=1 -> Y=8'h7F, COUT=1, V=1, N=0, latency 1.
- ASR A=8'h81 B=8'h03 -> IN_READY=0 for 3 EXEC cycles; OUT_VALID on the 4th cycle after accept with Y=8'hF0, COUT=0, N=1.
- Back-to-back: hold OUT_READY=0 for 5 cycles after an ADD -> Y/flags stable and IN_READY=0. Raise OUT_READY with a queued XOR A=8'h0F B=8'hFF -> XOR accepted in the same cycle; next cycle Y=8'hF0.
- Reset mid-op: ROL A=8'h01 B=8'h07, RST_N=0 during the 3rd EXEC cycle -> OUT_VALID never asserts for that op, all outputs 0. A following ADD 8'h02+8'h03 gives Y=8'h05 with latency 1.
- Opcode 1100, A=8'h10 B=8'h11:
  - With ALU_SEQ_MUL_EN -> after 9 cycles Y=8'h10, COUT=1.
  - Without it -> ERR=1, Y=0, latency 1.
  - Opcode 1111 -> ERR=1 in both builds.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and helpers for alu_seq (ALU_SEQ_MUL_EN adds multiply)
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MOVB = 4'b0010;
    localparam logic [3:0] OP_MOVA = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) || (op == OP_ROL) ||
               (op == OP_MUL);
`else
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) || (op == OP_ROL);
`endif
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational datapath for the eight single-cycle ALU operations
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        b_eff = op[0] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        y     = '0;
        cout  = 1'b0;
        v     = 1'b0;
        case ({1'b0, op})
            OP_ADD, OP_SUB: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                v    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOVB: y = b;
            OP_MOVA: y = a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered flags and multi-cycle shifts (ALU_SEQ_MUL_EN: multiply)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             err
);

    localparam int SHAMT_W = $clog2(WIDTH);
`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    localparam int CNT_W = SHAMT_W;
`endif

    state_t             state, state_n;
    logic               accept, start_exec, load, exec_last;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   sh_r, sh_next;
    logic               sh_out;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   core_y, res_y;
    logic               core_cout, core_v, res_cout, res_v, res_err;
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] p_r, p_next;
    logic [WIDTH:0]     p_sum;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .b    (b),
        .op   (s[2:0]),
        .cin  (cin),
        .y    (core_y),
        .cout (core_cout),
        .v    (core_v)
    );

    assign shamt      = b[SHAMT_W-1:0];
    assign in_ready   = rst_n && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
    assign accept     = in_valid && in_ready;
    // a zero-count shift finishes like a single-cycle op; multiply always iterates
    assign start_exec = is_multicycle(s) && (s[2] || (shamt != '0));
    assign exec_last  = (state == ST_EXEC) && (cnt_r == CNT_W'(1));
    assign load       = (accept && !start_exec) || exec_last;
    assign out_valid  = (state == ST_HOLD);

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) state_n = start_exec ? ST_EXEC : ST_HOLD;
                else if ((state == ST_HOLD) && out_ready) state_n = ST_IDLE;
            end
            ST_EXEC: if (cnt_r == CNT_W'(1)) state_n = ST_HOLD;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_next = sh_r;
        sh_out  = 1'b0;
        case (op_r)
            OP_SHL: begin sh_next = {sh_r[WIDTH-2:0], 1'b0};         sh_out = sh_r[WIDTH-1]; end
            OP_SHR: begin sh_next = {1'b0, sh_r[WIDTH-1:1]};         sh_out = sh_r[0];       end
            OP_ASR: begin sh_next = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]}; sh_out = sh_r[0];      end
            OP_ROL: begin sh_next = {sh_r[WIDTH-2:0], sh_r[WIDTH-1]}; sh_out = sh_r[WIDTH-1]; end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // shift-add: high half accumulates the multiplicand, low half drains the multiplier
    always_comb begin
        p_sum  = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, sh_r} : '0);
        p_next = {p_sum, p_r[WIDTH-1:1]};
    end
`endif

    always_comb begin
        res_y    = '0;
        res_cout = 1'b0;
        res_v    = 1'b0;
        res_err  = 1'b0;
        if (state == ST_EXEC) begin
`ifdef ALU_SEQ_MUL_EN
            if (op_r == OP_MUL) begin
                res_y    = p_next[WIDTH-1:0];
                res_cout = |p_next[2*WIDTH-1:WIDTH];
            end else begin
                res_y    = sh_next;
                res_cout = sh_out;
            end
`else
            res_y    = sh_next;
            res_cout = sh_out;
`endif
        end else if (!s[3]) begin
            res_y    = core_y;
            res_cout = core_cout;
            res_v    = core_v;
        end else if (s[3:2] == 2'b10) begin
            res_y = a;
        end else begin
            res_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_r  <= OP_ADD;
            sh_r  <= '0;
            cnt_r <= '0;
            y     <= '0;
            cout  <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
            v     <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            p_r   <= '0;
`endif
        end else begin
            state <= state_n;
            if (accept && start_exec) begin
                op_r <= s;
                sh_r <= a;
`ifdef ALU_SEQ_MUL_EN
                cnt_r <= s[2] ? CNT_W'(WIDTH) : CNT_W'(shamt);
                p_r   <= {{WIDTH{1'b0}}, b};
`else
                cnt_r <= shamt;
`endif
            end else if (state == ST_EXEC) begin
                sh_r  <= sh_next;
                cnt_r <= cnt_r - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                p_r   <= p_next;
`endif
            end
            if (load) begin
                y    <= res_y;
                cout <= res_cout;
                v    <= res_v;
                err  <= res_err;
                z    <= !res_err && (res_y == '0);
                n    <= res_y[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (honours ALU_SEQ_MUL_EN)
module tb_alu_seq;

    typedef struct packed {
        logic [7:0] y;
        logic       cout, z, n, v, err;
        int         lat;
    } exp_t;

    typedef struct packed {
        logic [7:0] a, b;
        logic [3:0] s;
        logic       cin;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready;
    logic [7:0] a, b, y;
    logic [3:0] s;
    logic       cout, z, n, v, err;
    int         errors = 0;
    int         checks = 0;
    vec_t       tbl[16];

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .z         (z),
        .n         (n),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] ta, tb2, input logic [3:0] ts, input logic tc,
                                input logic [7:0] ey, input logic ec, ez, en, ev, ee,
                                input int el);
        vec_t r;
        r.a = ta; r.b = tb2; r.s = ts; r.cin = tc;
        r.e.y = ey; r.e.cout = ec; r.e.z = ez; r.e.n = en; r.e.v = ev; r.e.err = ee;
        r.e.lat = el;
        return r;
    endfunction

    function automatic exp_t model(input logic [7:0] ma, mb, input logic [3:0] ms, input logic mc);
        exp_t e;
        logic [8:0]  sum;
        logic [7:0]  nb;
        logic [15:0] full;
        int          k;
        e = '0;
        e.lat = 1;
        k = int'(mb[2:0]);
        nb = ~mb;
        case (ms)
            4'd0: begin
                sum = ma + mb + mc;
                e.y = sum[7:0]; e.cout = sum[8];
                e.v = (ma[7] == mb[7]) && (e.y[7] != ma[7]);
            end
            4'd1: begin
                sum = ma + nb + mc;
                e.y = sum[7:0]; e.cout = sum[8];
                e.v = (ma[7] == nb[7]) && (e.y[7] != ma[7]);
            end
            4'd2: e.y = mb;
            4'd3: e.y = ma;
            4'd4: e.y = ma & mb;
            4'd5: e.y = ma | mb;
            4'd6: e.y = ~ma;
            4'd7: e.y = ma ^ mb;
            4'd8: begin
                full = {8'h00, ma} << k;
                e.y = full[7:0]; e.cout = (k != 0) && full[8]; e.lat = 1 + k;
            end
            4'd9: begin
                full = {ma, 8'h00} >> k;
                e.y = full[15:8]; e.cout = (k != 0) && full[7]; e.lat = 1 + k;
            end
            4'd10: begin
                full = 16'($signed({ma, 8'h00}) >>> k);
                e.y = full[15:8]; e.cout = (k != 0) && full[7]; e.lat = 1 + k;
            end
            4'd11: begin
                e.y = (k == 0) ? ma : 8'((ma << k) | (ma >> (8 - k)));
                e.cout = (k != 0) && e.y[0]; e.lat = 1 + k;
            end
`ifdef ALU_SEQ_MUL_EN
            4'd12: begin
                full = ma * mb;
                e.y = full[7:0]; e.cout = |full[15:8]; e.lat = 9;
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.z = !e.err && (e.y == 8'h00);
        e.n = e.y[7];
        return e;
    endfunction

    // called at a negedge; returns at the negedge where the result is visible
    task automatic run_op(input logic [7:0] ta, tb2, input logic [3:0] ts, input logic tc,
                          input exp_t e, input string tag);
        int lat;
        bit leak;
        in_valid = 1'b1; a = ta; b = tb2; s = ts; cin = tc;
        #1;
        chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); s = 4'($urandom); cin = 1'($urandom);
        lat = 1;
        leak = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (in_ready) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(e.lat));
        chk($sformatf("%s y", tag), 32'(y), 32'(e.y));
        chk($sformatf("%s flags{c,z,n,v,err}", tag), 32'({cout, z, n, v, err}),
            32'({e.cout, e.z, e.n, e.v, e.err}));
        chk($sformatf("%s exec in_ready low", tag), 32'(leak), 32'd0);
    endtask

    initial begin
        bit leak;
        tbl[0]  = mk(8'hFF, 8'h01, 4'h0, 1'b0, 8'h00, 1, 1, 0, 0, 0, 1);
        tbl[1]  = mk(8'h80, 8'h01, 4'h1, 1'b1, 8'h7F, 1, 0, 0, 1, 0, 1);
        tbl[2]  = mk(8'h81, 8'h03, 4'hA, 1'b0, 8'hF0, 0, 0, 1, 0, 0, 4);
        tbl[3]  = mk(8'h0F, 8'hFF, 4'h7, 1'b0, 8'hF0, 0, 0, 1, 0, 0, 1);
        tbl[4]  = mk(8'h02, 8'h03, 4'h0, 1'b0, 8'h05, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(8'h10, 8'h11, 4'hF, 1'b0, 8'h00, 0, 0, 0, 0, 1, 1);
`ifdef ALU_SEQ_MUL_EN
        tbl[6]  = mk(8'h10, 8'h11, 4'hC, 1'b0, 8'h10, 1, 0, 0, 0, 0, 9);
`else
        tbl[6]  = mk(8'h10, 8'h11, 4'hC, 1'b0, 8'h00, 0, 0, 0, 0, 1, 1);
`endif
        tbl[7]  = mk(8'h81, 8'h01, 4'h8, 1'b0, 8'h02, 1, 0, 0, 0, 0, 2);
        tbl[8]  = mk(8'h81, 8'h01, 4'hB, 1'b0, 8'h03, 1, 0, 0, 0, 0, 2);
        tbl[9]  = mk(8'h81, 8'h08, 4'h9, 1'b0, 8'h81, 0, 0, 1, 0, 0, 1);
        tbl[10] = mk(8'h7F, 8'h00, 4'h0, 1'b1, 8'h80, 0, 0, 1, 1, 0, 1);
        tbl[11] = mk(8'hFF, 8'h00, 4'h6, 1'b0, 8'h00, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk(8'h3C, 8'hA5, 4'h2, 1'b0, 8'hA5, 0, 0, 1, 0, 0, 1);
        tbl[13] = mk(8'hC3, 8'h0F, 4'h4, 1'b0, 8'h03, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(8'h81, 8'h07, 4'h9, 1'b0, 8'h01, 0, 0, 0, 0, 0, 8);
        tbl[15] = mk(8'h05, 8'h07, 4'h1, 1'b1, 8'hFE, 0, 0, 1, 0, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; s = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset outputs", 32'({out_valid, y, cout, z, n, v, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].cin, tbl[i].e, $sformatf("vec%0d", i));

        // backpressure: ADD held for 5 cycles, queued XOR accepted as OUT_READY rises
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h11; b = 8'h22; s = 4'h0; cin = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h0F; b = 8'hFF; s = 4'h7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d y/valid/ready", i), 32'({y, out_valid, in_ready}),
                32'({8'h33, 1'b1, 1'b0}));
            chk($sformatf("hold%0d flags", i), 32'({cout, z, n, v, err}), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("hold release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b xor valid/y/n", 32'({out_valid, y, n}), 32'({1'b1, 8'hF0, 1'b1}));
        @(negedge clk);
        chk("b2b drained", 32'(out_valid), 32'd0);

        // reset during the third EXEC cycle of a 7-step rotate
        in_valid = 1'b1; a = 8'h01; b = 8'h07; s = 4'hB; cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rol exec no valid", 32'({out_valid, in_ready}), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midop reset outputs", 32'({out_valid, in_ready, y, cout, z, n, v, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        leak = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) leak = 1'b1;
        end
        chk("aborted rol silent", 32'(leak), 32'd0);
        run_op(8'h02, 8'h03, 4'h0, 1'b0, model(8'h02, 8'h03, 4'h0, 1'b0), "post-reset add");

        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rs;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 4'($urandom_range(0, 15)); rc = 1'($urandom);
            run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), $sformatf("rnd%0d op%0h", i, rs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
